status_encoder: RTL
===================

Name: status_encoder

Overview:
- Return-path counterpart of the command decoder: packs events and measurements from the ultrasonic TX/RX datapath into one status word for the AXI side.
- The status word uses the same bit layout as the command word, so software decodes both with one map.
- Events are held in sticky pending registers, so bursts are not lost while a word waits for the host.
- One word is presented at a time with a valid/ack handshake; a counter tracks events that collapsed onto an already-pending flag.

Parameters:
DATA_WIDTH, 15, width of status_data
AMOUNT_WIDTH, 8, width of amount_in; must equal DATA_WIDTH-7
CNT_WIDTH, 8, width of ovf_cnt

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
power_on  in  1  transducer power level, held
inc_done  in  1  one-cycle pulse: amplitude increase applied
dec_done  in  1  one-cycle pulse: amplitude decrease applied
rx_evt  in  1  one-cycle pulse: echo received
tx_evt  in  1  one-cycle pulse: burst sent
amount_valid  in  1  one-cycle pulse: amount_in holds a new measurement
amount_in  in  AMOUNT_WIDTH  measurement value
status_ack  in  1  host has consumed status_data
clr_ovf  in  1  clears ovf_cnt
status_data  out  DATA_WIDTH  packed status word
status_valid  out  1  status_data is valid and stable
ovf_cnt  out  CNT_WIDTH  saturating count of collapsed events

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high (clk, rst).
- Reset: status_data=0, status_valid=0, ovf_cnt=0. All pending flags and the amount latch clear. FSM enters IDLE. Registered power_on copy loads 0.
- Status word bits:
  - bit0 = power_on and bit1 = ~power_on, sampled at LOAD.
  - bit2 inc, bit3 dec, bit4 rx, bit5 tx: pending flags.
  - bit6 = amount pending.
  - [DATA_WIDTH-1:7] = latched amount when bit6 is set, else 0.
- Pending flags (inc, dec, rx, tx, amt, pwr):
  - A flag sets on its input pulse.
  - pwr sets when power_on differs from its registered copy.
  - amount_valid latches amount_in; the latest value wins.
  - Flags clear only at LOAD, and only those that were packed.
  - A set arriving in the LOAD cycle wins and is reported in the next word.
- FSM states: IDLE, LOAD, SEND.
  - IDLE -> LOAD when any flag is pending.
  - LOAD, one cycle: register status_data from flags and power_on, clear packed flags, go to SEND, set status_valid=1.
  - SEND: status_data and status_valid are held stable. When status_ack=1 is sampled: status_valid=0, go to IDLE.
- Latency:
  - Event pulse sampled at edge N -> flag set after N -> LOAD after N+1 -> status_valid=1 after N+2.
  - Ack sampled at edge M -> status_valid=0 after M. Earliest next valid is after M+2.
- status_ack outside SEND is ignored. Events during SEND are held pending.
- Overflow:
  - Occurs when an input pulse arrives while its flag is already set and not being cleared that cycle. An amount_valid overflow also overwrites the latched amount.
  - ovf_cnt increments by 1 per cycle with at least one overflow, regardless of how many flags overflowed.
  - ovf_cnt saturates at 2^CNT_WIDTH-1.
  - clr_ovf has priority over increment in the same cycle.
- A power_on toggle that returns to its original level before LOAD still produces a word; bits 0/1 show the level at LOAD.
- Reset asserted in any state overrides everything: outputs and state return to reset values on the next edge. An in-flight word is dropped.

Test Plan:
1. Hold rst 3 cycles with random inputs toggling -> status_data=0, status_valid=0, ovf_cnt=0; no valid for 5 cycles after release with inputs idle.
2. power_on=1 steady; rx_evt pulse sampled at edge 10 -> status_valid=1 after edge 12 with status_data=0x0011; status_ack at edge 15 -> status_valid=0 after 15; status_data held unchanged 12..15.
3. power_on=1; amount_valid with amount_in=0xA5 -> status_data=0x52C1; a second word after ack with no new events never appears.
4. In SEND with no ack, pulse tx_evt then inc_done -> first word unchanged; after ack a second word appears with bits2 and 5 set (0x0025 with power_on=1); ovf_cnt=0.
5. Two rx_evt pulses while the rx flag is pending -> ovf_cnt=1. Force 300 overflows -> ovf_cnt=255 (saturated). clr_ovf together with an overflow -> ovf_cnt=0.
6. Assert rst during SEND with flags pending -> status_valid=0 after the edge; after release no word is produced until a new event.

Source files
------------

// File: rtl/status_encoder.sv
// status_encoder: packs TX/RX datapath events and measurements into one
// status word (same bit layout as the command word) and presents it to the
// host with a valid/ack handshake. Events are held in sticky pending flags
// until the word that reports them is loaded. Events that land on a flag
// that is already pending are counted in a saturating counter.
//
// Status word layout:
//   bit 0                  power_on level at LOAD
//   bit 1                  inverse of power_on level at LOAD
//   bit 2                  amplitude increase applied
//   bit 3                  amplitude decrease applied
//   bit 4                  echo received
//   bit 5                  burst sent
//   bit 6                  amount field valid
//   [DATA_WIDTH-1:7]       latched amount (zero when bit 6 is clear)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no word presented; waiting for any pending flag
// LOAD  | one cycle: capture word, clear the flags that were packed
// SEND  | word presented and held stable until the host acks it
//
// AMOUNT_WIDTH must equal DATA_WIDTH-7 so the amount fills the upper field.

module status_encoder #(
    parameter int DATA_WIDTH   = 15,
    parameter int AMOUNT_WIDTH = 8,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    power_on,
    input  logic                    inc_done,
    input  logic                    dec_done,
    input  logic                    rx_evt,
    input  logic                    tx_evt,
    input  logic                    amount_valid,
    input  logic [AMOUNT_WIDTH-1:0] amount_in,
    input  logic                    status_ack,
    input  logic                    clr_ovf,
    output logic [DATA_WIDTH-1:0]   status_data,
    output logic                    status_valid,
    output logic [CNT_WIDTH-1:0]    ovf_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_load;

    logic                    r_pwr_q;
    logic                    w_pwr_chg;

    logic                    r_inc_pend;
    logic                    r_dec_pend;
    logic                    r_rx_pend;
    logic                    r_tx_pend;
    logic                    r_amt_pend;
    logic                    r_pwr_pend;
    logic [AMOUNT_WIDTH-1:0] r_amount;
    logic                    w_any_pend;

    logic                    w_ovf_inc;
    logic                    w_ovf_dec;
    logic                    w_ovf_rx;
    logic                    w_ovf_tx;
    logic                    w_ovf_amt;
    logic                    w_any_ovf;

    logic [DATA_WIDTH-1:0]   w_word;
    logic [DATA_WIDTH-1:0]   r_status_data;
    logic                    r_status_valid;
    logic [CNT_WIDTH-1:0]    r_ovf_cnt;

    assign w_pwr_chg  = (power_on != r_pwr_q);
    assign w_any_pend = r_inc_pend | r_dec_pend | r_rx_pend | r_tx_pend
                      | r_amt_pend | r_pwr_pend;

    // Every flag that is pending in LOAD is packed, so LOAD clears them all.
    // A pulse arriving in the same cycle re-sets its flag for the next word.
    assign w_ovf_inc = inc_done     & r_inc_pend & ~w_load;
    assign w_ovf_dec = dec_done     & r_dec_pend & ~w_load;
    assign w_ovf_rx  = rx_evt       & r_rx_pend  & ~w_load;
    assign w_ovf_tx  = tx_evt       & r_tx_pend  & ~w_load;
    assign w_ovf_amt = amount_valid & r_amt_pend & ~w_load;
    assign w_any_ovf = w_ovf_inc | w_ovf_dec | w_ovf_rx | w_ovf_tx | w_ovf_amt;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and load strobe
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_pend) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load       = 1'b1;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (status_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Assemble the word from the current flags and the live power level
    always_comb begin
        w_word    = '0;
        w_word[0] = power_on;
        w_word[1] = ~power_on;
        w_word[2] = r_inc_pend;
        w_word[3] = r_dec_pend;
        w_word[4] = r_rx_pend;
        w_word[5] = r_tx_pend;
        w_word[6] = r_amt_pend;
        if (r_amt_pend) begin
            w_word[DATA_WIDTH-1:7] = r_amount;
        end
    end

    // Registered power level used to detect a level change
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwr_q <= 1'b0;
        end else begin
            r_pwr_q <= power_on;
        end
    end

    // Sticky pending flags: set on event, cleared only when packed in LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inc_pend <= 1'b0;
            r_dec_pend <= 1'b0;
            r_rx_pend  <= 1'b0;
            r_tx_pend  <= 1'b0;
            r_amt_pend <= 1'b0;
            r_pwr_pend <= 1'b0;
        end else begin
            r_inc_pend <= inc_done     | (r_inc_pend & ~w_load);
            r_dec_pend <= dec_done     | (r_dec_pend & ~w_load);
            r_rx_pend  <= rx_evt       | (r_rx_pend  & ~w_load);
            r_tx_pend  <= tx_evt       | (r_tx_pend  & ~w_load);
            r_amt_pend <= amount_valid | (r_amt_pend & ~w_load);
            r_pwr_pend <= w_pwr_chg    | (r_pwr_pend & ~w_load);
        end
    end

    // Amount latch: the most recent measurement always wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_amount <= '0;
        end else if (amount_valid) begin
            r_amount <= amount_in;
        end
    end

    // Output word register, loaded once per word and held through SEND
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status_data <= '0;
        end else if (w_load) begin
            r_status_data <= w_word;
        end
    end

    // Valid follows the state the FSM is entering
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status_valid <= 1'b0;
        end else begin
            r_status_valid <= (w_state_next == ST_SEND);
        end
    end

    // Collapsed-event counter: one step per cycle with any overflow, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (clr_ovf) begin
            r_ovf_cnt <= '0;
        end else if (w_any_ovf && (r_ovf_cnt != CNT_MAX)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign status_data  = r_status_data;
    assign status_valid = r_status_valid;
    assign ovf_cnt      = r_ovf_cnt;

endmodule
